video_cfg_ctrl: RTL



---
 rtl/video_cfg_ctrl_if.sv | 19 +
 rtl/video_cfg_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/video_cfg_ctrl_if.sv
// MCU byte link into the controller and the forwarded byte stream out to the OSD overlay.
interface video_cfg_ctrl_if;
  logic       mcu_start;
  logic       mcu_strobe;
  logic [7:0] mcu_data;
  logic       osd_start;
  logic       osd_strobe;
  logic [7:0] osd_data;

  modport master (
    output mcu_start, mcu_strobe, mcu_data,
    input  osd_start, osd_strobe, osd_data
  );

  modport slave (
    input  mcu_start, mcu_strobe, mcu_data,
    output osd_start, osd_strobe, osd_data
  );
endinterface

// File: rtl/video_cfg_ctrl.sv
// MCU transfer demux: OSD bytes are forwarded, config bytes are shadowed and
// committed at vsync (or by watchdog when video is stopped).
module video_cfg_ctrl #(
  parameter int unsigned COMMIT_TIMEOUT = 1048576,
  parameter logic [1:0]  DEF_SCANLINES  = 2'd0,
  parameter logic [1:0]  DEF_VOLUME     = 2'd3,
  parameter logic        DEF_WIDE       = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  video_cfg_ctrl_if.slave     bus,
  input  logic                vs_in_n,
  output logic [1:0]          system_scanlines,
  output logic [1:0]          system_volume,
  output logic                system_wide_screen,
  output logic                cfg_pending,
  output logic                bad_cmd
);

  localparam int unsigned      WD_W    = $clog2(COMMIT_TIMEOUT) + 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(COMMIT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CMD, OSD_FWD, CFG, DISCARD} state_t;

  state_t          state, state_next;
  logic            osd_start_next, osd_strobe_next, bad_next, cfg_load;
  logic [1:0]      shadow_scanlines, shadow_volume;
  logic            shadow_wide;
  logic [WD_W-1:0] wd;
  logic            vs_q, vs_fall, commit;

  assign vs_fall = vs_q & ~vs_in_n;
  // A payload in the same cycle as a commit wins; the commit is deferred.
  assign commit  = cfg_pending & (vs_fall | (wd == WD_LAST)) & ~cfg_load;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    osd_start_next  = 1'b0;
    osd_strobe_next = 1'b0;
    bad_next        = 1'b0;
    cfg_load        = 1'b0;
    if (bus.mcu_start) begin
      state_next = CMD;
    end else if (bus.mcu_strobe) begin
      case (state)
        CMD: begin
          case (bus.mcu_data)
            8'h01: state_next = CFG;
            8'h02: begin
              state_next     = OSD_FWD;
              osd_start_next = 1'b1;
            end
            default: begin
              state_next = DISCARD;
              bad_next   = 1'b1;
            end
          endcase
        end
        OSD_FWD: osd_strobe_next = 1'b1;
        CFG: begin
          cfg_load   = 1'b1;
          state_next = DISCARD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.osd_start      <= 1'b0;
      bus.osd_strobe     <= 1'b0;
      bus.osd_data       <= '0;
      bad_cmd            <= 1'b0;
      vs_q               <= 1'b1;
      shadow_scanlines   <= DEF_SCANLINES;
      shadow_volume      <= DEF_VOLUME;
      shadow_wide        <= DEF_WIDE;
      system_scanlines   <= DEF_SCANLINES;
      system_volume      <= DEF_VOLUME;
      system_wide_screen <= DEF_WIDE;
      cfg_pending        <= 1'b0;
      wd                 <= '0;
    end else begin
      bus.osd_start  <= osd_start_next;
      bus.osd_strobe <= osd_strobe_next;
      bad_cmd        <= bad_next;
      vs_q           <= vs_in_n;
      if (osd_strobe_next) bus.osd_data <= bus.mcu_data;

      if (cfg_load) begin
        shadow_scanlines <= bus.mcu_data[1:0];
        shadow_volume    <= bus.mcu_data[3:2];
        shadow_wide      <= bus.mcu_data[4];
        cfg_pending      <= 1'b1;
        wd               <= '0;
      end else if (commit) begin
        system_scanlines   <= shadow_scanlines;
        system_volume      <= shadow_volume;
        system_wide_screen <= shadow_wide;
        cfg_pending        <= 1'b0;
        wd                 <= '0;
      end else if (cfg_pending && wd < WD_LAST) begin
        wd <= wd + WD_W'(1);
      end
    end
  end

endmodule
